// File: rtl/riscv_pkg.sv
// Shared constants, FSM encoding and request payload for the load/store path.
package riscv_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned MEM_ADDR_W = 7;
  localparam int unsigned BYTE_ADDR_W = MEM_ADDR_W + 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic                   we;
    logic [2:0]             funct3;
    logic [BYTE_ADDR_W-1:0] addr;
    logic [WORD_WIDTH-1:0]  wdata;
  } mem_req_t;

  // Illegal size/sign encoding or an access not aligned to its size.
  function automatic logic req_is_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (we && (funct3 > F3_W));
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3 == F3_W) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// Extracts the addressed byte/halfword from a RAM word and sign- or zero-extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] rdata,
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  output logic [WORD_WIDTH-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = 8'h00;
    case (addr_lo)
      2'd0:    byte_c = rdata[7:0];
      2'd1:    byte_c = rdata[15:8];
      2'd2:    byte_c = rdata[23:16];
      default: byte_c = rdata[31:24];
    endcase
    half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data_c = '0;
    case (funct3)
      F3_B:    data_c = {{24{byte_c[7]}}, byte_c};
      F3_H:    data_c = {{16{half_c[15]}}, half_c};
      F3_W:    data_c = rdata;
      F3_BU:   data_c = {24'h000000, byte_c};
      F3_HU:   data_c = {16'h0000, half_c};
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller in front of a 128x32 RAM without byte enables;
// sub-word stores run as read-modify-write.
module data_mem_ctrl
  import riscv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [MEM_ADDR_W+1:0]   req_addr,
  input  logic [WORD_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [WORD_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  output logic [WORD_WIDTH-1:0]   mem_wdata,
  input  logic [WORD_WIDTH-1:0]   mem_rdata
);

  state_e                state_q, state_d;
  mem_req_t              req_q, req_d;
  logic                  err_q, err_d;
  logic [WORD_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_WIDTH-1:0] load_data_c;
  logic [WORD_WIDTH-1:0] merged_c;
  logic                  req_err_c;

  assign req_err_c = req_is_err(req_we, req_funct3, req_addr[1:0]);

  load_align u_load_align (
    .rdata   (mem_rdata),
    .funct3  (req_q.funct3),
    .addr_lo (req_q.addr[1:0]),
    .data_c  (load_data_c)
  );

  // Replace only the addressed byte/halfword of the word read back from RAM.
  always_comb begin
    merged_c = mem_rdata;
    if (req_q.funct3 == F3_B) begin
      case (req_q.addr[1:0])
        2'd0:    merged_c[7:0]   = req_q.wdata[7:0];
        2'd1:    merged_c[15:8]  = req_q.wdata[7:0];
        2'd2:    merged_c[23:16] = req_q.wdata[7:0];
        default: merged_c[31:24] = req_q.wdata[7:0];
      endcase
    end else if (req_q.funct3 == F3_H) begin
      if (req_q.addr[1]) merged_c[31:16] = req_q.wdata[15:0];
      else               merged_c[15:0]  = req_q.wdata[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    err_d        = err_q;
    resp_rdata_d = resp_rdata_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          err_d = req_err_c;
          if (req_err_c) begin
            resp_rdata_d = '0;
            state_d      = RESP;
          end else if (req_we && (req_funct3 == F3_W)) begin
            mem_wdata_d = req_wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (req_q.we) begin
          mem_wdata_d = merged_c;
          state_d     = WRITE;
        end else begin
          resp_rdata_d = load_data_c;
          state_d      = RESP;
        end
      end
      WRITE: begin
        resp_rdata_d = '0;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      err_q        <= 1'b0;
      resp_rdata_q <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      err_q        <= err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Every RAM-side output is a decode of registered state or a flop.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_rd_en  = (state_q == READ);
  assign mem_wr_en  = (state_q == WRITE);
  assign mem_addr   = req_q.addr[MEM_ADDR_W+1:2];
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: RAM model, reference memory and response scoreboard.
module tb_data_mem_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [6:0]  mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          lat;
    int          exp_lat;
    int          rd_cnt;
    int          wr_cnt;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rdata;
    logic        err;
    logic        rdy;
  } obs_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [128];
  logic [31:0] ram [128];
  logic        ram_clear;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 128; i++) ram[i] <= 32'h0;
    end else if (mem_wr_en) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Reference behaviour: expected response and latency; updates ref_mem on stores.
  task automatic predict(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd, output logic [31:0] rdata,
                         output logic err, output int lat);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    int          bsh;
    int          hsh;
    w   = ref_mem[addr[8:2]];
    bsh = 8 * int'(addr[1:0]);
    hsh = 16 * int'(addr[1]);
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
          (we && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)) ||
          ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) ||
          ((f3 == 3'b010) && (addr[1:0] != 2'b00));
    rdata = 32'h0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      if (f3 == 3'b000) begin
        w   = (w & ~(32'h000000FF << bsh)) | ({24'h0, wd[7:0]} << bsh);
        lat = 3;
      end else if (f3 == 3'b001) begin
        w   = (w & ~(32'h0000FFFF << hsh)) | ({16'h0, wd[15:0]} << hsh);
        lat = 3;
      end else begin
        w   = wd;
        lat = 2;
      end
      ref_mem[addr[8:2]] = w;
    end else begin
      lat = 2;
      b   = w >> bsh;
      h   = w >> hsh;
      case (f3)
        3'b000:  rdata = {{24{b[7]}}, b[7:0]};
        3'b001:  rdata = {{16{h[15]}}, h[15:0]};
        3'b100:  rdata = {24'h0, b[7:0]};
        3'b101:  rdata = {16'h0, h[15:0]};
        default: rdata = w;
      endcase
    end
  endtask

  // Drive one request at max rate, record RAM activity, score the response.
  task automatic run(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                     input logic [31:0] wd, input string name, output obs_t o);
    exp_t e;
    predict(we, f3, addr, wd, e.rdata, e.err, o.exp_lat);
    exp_q.push_back(e);
    o.lat = -1; o.rd_cnt = 0; o.wr_cnt = 0; o.wr_addr = '0; o.wr_data = '0;
    o.rdata = '0; o.err = 1'b0;
    @(negedge clk);
    o.rdy      = req_ready;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_rd_en === 1'b1) o.rd_cnt++;
      if (mem_wr_en === 1'b1) begin
        o.wr_cnt++;
        o.wr_addr = mem_addr;
        o.wr_data = mem_wdata;
      end
      if (resp_valid === 1'b1) begin
        o.lat   = c;
        o.rdata = resp_rdata;
        o.err   = resp_err;
        e = exp_q.pop_front();
        n_tests++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          n_fail++;
          $display("FAIL %s scoreboard: got err=%b data=%h, expected err=%b data=%h",
                   name, resp_err, resp_rdata, e.err, e.rdata);
        end
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b0; ram_clear = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 9'h000; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    ram_clear = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({req_ready, resp_valid, resp_err, mem_rd_en, mem_wr_en} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/rv/err/rd/wr=%b, expected 10000",
               {req_ready, resp_valid, resp_err, mem_rd_en, mem_wr_en});
    end
    n_tests++;
    if (resp_rdata !== 32'h0 || mem_addr !== 7'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, expected all 0",
               resp_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b0 || mem_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_accept: got ready=%b rd_en=%b, expected 0 1", req_ready, mem_rd_en);
    end
    lat = -1;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    n_tests++;
    if (lat !== 2 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_load: got lat=%0d data=%h err=%b, expected 2 00000000 0",
               lat, resp_rdata, resp_err);
    end
  endtask

  task automatic test_word();
    obs_t o;
    run(1'b1, F3_W, 9'h010, 32'hDEADBEEF, "sw", o);
    n_tests++;
    if (o.lat !== 2 || o.rd_cnt !== 0 || o.wr_cnt !== 1) begin
      n_fail++;
      $display("FAIL sw_timing: got lat=%0d rd=%0d wr=%0d, expected 2 0 1", o.lat, o.rd_cnt, o.wr_cnt);
    end
    n_tests++;
    if (o.wr_addr !== 7'd4 || o.wr_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_write: got addr=%0d data=%h, expected 4 deadbeef", o.wr_addr, o.wr_data);
    end
    run(1'b0, F3_W, 9'h010, 32'h0, "lw", o);
    n_tests++;
    if (o.lat !== 2 || o.rd_cnt !== 1 || o.rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw: got lat=%0d rd=%0d data=%h, expected 2 1 deadbeef", o.lat, o.rd_cnt, o.rdata);
    end
  endtask

  task automatic test_byte_rmw();
    obs_t o;
    run(1'b1, F3_B, 9'h013, 32'h000000A5, "sb", o);
    n_tests++;
    if (o.lat !== 3 || o.rd_cnt !== 1 || o.wr_cnt !== 1 || o.wr_data !== 32'hA5ADBEEF) begin
      n_fail++;
      $display("FAIL sb_rmw: got lat=%0d rd=%0d wr=%0d data=%h, expected 3 1 1 a5adbeef",
               o.lat, o.rd_cnt, o.wr_cnt, o.wr_data);
    end
    run(1'b0, F3_B, 9'h013, 32'h0, "lb", o);
    n_tests++;
    if (o.rdata !== 32'hFFFFFFA5) begin
      n_fail++;
      $display("FAIL lb: got %h expected ffffffa5", o.rdata);
    end
    run(1'b0, F3_BU, 9'h013, 32'h0, "lbu", o);
    n_tests++;
    if (o.rdata !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL lbu: got %h expected 000000a5", o.rdata);
    end
  endtask

  task automatic test_halfword();
    obs_t o;
    run(1'b1, F3_H, 9'h012, 32'h00001234, "sh", o);
    n_tests++;
    if (o.lat !== 3 || o.wr_data !== 32'h1234BEEF) begin
      n_fail++;
      $display("FAIL sh_rmw: got lat=%0d data=%h, expected 3 1234beef", o.lat, o.wr_data);
    end
    run(1'b0, F3_H, 9'h010, 32'h0, "lh_lo", o);
    n_tests++;
    if (o.rdata !== 32'hFFFFBEEF) begin
      n_fail++;
      $display("FAIL lh_lo: got %h expected ffffbeef", o.rdata);
    end
    run(1'b0, F3_HU, 9'h010, 32'h0, "lhu_lo", o);
    n_tests++;
    if (o.rdata !== 32'h0000BEEF) begin
      n_fail++;
      $display("FAIL lhu_lo: got %h expected 0000beef", o.rdata);
    end
    run(1'b0, F3_H, 9'h012, 32'h0, "lh_hi", o);
    n_tests++;
    if (o.rdata !== 32'h00001234) begin
      n_fail++;
      $display("FAIL lh_hi: got %h expected 00001234", o.rdata);
    end
  endtask

  task automatic test_errors();
    obs_t        o;
    logic        we_t [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3_t [4]  = '{F3_W, F3_H, 3'b011, F3_BU};
    logic [8:0]  ad_t [4]  = '{9'h011, 9'h001, 9'h010, 9'h010};
    for (int i = 0; i < 4; i++) begin
      run(we_t[i], f3_t[i], ad_t[i], 32'hFFFFFFFF, "err", o);
      n_tests++;
      if (o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.rd_cnt !== 0 || o.wr_cnt !== 0) begin
        n_fail++;
        $display("FAIL err_case%0d: got lat=%0d err=%b data=%h rd=%0d wr=%0d, expected 1 1 0 0 0",
                 i, o.lat, o.err, o.rdata, o.rd_cnt, o.wr_cnt);
      end
    end
    run(1'b0, F3_W, 9'h010, 32'h0, "err_after_lw", o);
    n_tests++;
    if (o.rdata !== 32'h1234BEEF) begin
      n_fail++;
      $display("FAIL err_ram_intact: got %h expected 1234beef", o.rdata);
    end
  endtask

  task automatic test_reset_mid_rmw();
    obs_t o;
    run(1'b1, F3_W, 9'h000, 32'h11223344, "mid_pre_sw", o);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 9'h000; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_read: got rd_en=%b expected 1", mem_rd_en);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async_drop: got rd=%b wr=%b expected 0 0", mem_rd_en, mem_wr_en);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (mem_wr_en !== 1'b0 || resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_quiet%0d: got wr=%b rv=%b expected 0 0", c, mem_wr_en, resp_valid);
      end
    end
    rst = 1'b1;
    run(1'b0, F3_W, 9'h000, 32'h0, "mid_post_lw", o);
    n_tests++;
    if (o.rdata !== 32'h11223344) begin
      n_fail++;
      $display("FAIL mid_no_write: got %h expected 11223344", o.rdata);
    end
  endtask

  task automatic test_back_to_back();
    obs_t        o;
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  ad;
    logic [31:0] wd;
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      ad = 9'($urandom_range(0, 511));
      wd = $urandom;
      run(we, f3, ad, wd, "b2b", o);
      n_tests++;
      if (o.lat !== o.exp_lat || o.rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b%0d we=%b f3=%b addr=%h: got lat=%0d ready=%b, expected %0d 1",
                 i, we, f3, ad, o.lat, o.rdy, o.exp_lat);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_word();
    test_byte_rmw();
    test_halfword();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
